pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It watches the Decode, Execute, Memory and Writeback stage identifiers and drives the per-stage `stall`, `nop` and active-low `WEN` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also drives the Decode-stage forwarding selects and the halt drain sequence. It holds a small FSM plus performance counters, and sits beside the pipeline registers in the core top level.

## Interface
- `CNT_W`, default 16: width of the saturating `stall_cycles` counter.
- `FLUSH_W`, default 8: width of the saturating `flush_count` counter.

Ports:
- `CLK`, in, 1: clock. All state updates on the negedge, same as the pipeline registers.
- `RST`, in, 1: reset, asynchronous, active-low.
- `RegAName_D`, `RegBName_D`, in, 5 each: Decode source register indices.
- `UsesA_D`, `UsesB_D`, in, 1 each: Decode instruction reads rs1 / rs2.
- `Rdst_E`, `Rdst_M`, in, 5 each: destination register in EX / MEM.
- `RegWrEn_E`, `RegWrEn_M`, in, 1 each: register write enable, active-low.
- `IsLoad_E`, in, 1: EX instruction is a load.
- `Redirect_E`, in, 1: taken branch or jump resolved in EX.
- `MemBusy`, in, 1: data memory not ready this cycle.
- `halt_D`, `halt_W`, in, 1 each: halt instruction in Decode / Writeback.
- `stall_D`, `nop_D`, out, 1 each: to IF/ID. `stall_F` holds the PC.
- `stall_F`, out, 1: hold the PC.
- `stall_E`, `nop_E`, out, 1 each: to ID/EX (data and ctrl).
- `nop_M`, out, 1: to EX/MEM (data and ctrl).
- `WEN_M`, `WEN_W`, out, 1 each: active-low write enables for EX/MEM and MEM/WB.
- `FwdA_sel`, `FwdB_sel`, out, 2 each: 00 register file, 01 EX result, 10 MEM result.
- `halted`, out, 1: core stopped.
- `stall_cycles`, out, `CNT_W`: saturating count of stall cycles.
- `flush_count`, out, `FLUSH_W`: saturating count of redirects.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `DRAIN`, `HALTED`.
- Stall and nop outputs are Mealy: a combinational function of state and inputs.
- Output priority, in `RUN` / `MEM_WAIT` / `DRAIN`:
  1. `MemBusy`: `stall_F`=`stall_D`=`stall_E`=1, `WEN_M`=`WEN_W`=1 (hold). Next state is `MEM_WAIT`. `Redirect_E` stays pending because EX is held.
  2. `Redirect_E`: `nop_D`=`nop_E`=1, PC not stalled. Squashes 2 younger instructions. Next state is `RUN`, including from `DRAIN`, because the halt was squashed. `flush_count` increments.
  3. Load-use, i.e. `IsLoad_E` & !`RegWrEn_E` & `Rdst_E`≠0 & ((`UsesA_D` & `RegAName_D`==`Rdst_E`) | (`UsesB_D` & `RegBName_D`==`Rdst_E`)): `stall_F`=`stall_D`=1, `nop_E`=1. Exactly one bubble.
  4. `halt_D` in `RUN`: next state is `DRAIN`. The halt instruction advances normally.
  5. In `DRAIN`: `stall_F`=1 and `nop_D`=1 every cycle. When `halt_W`=1, next state is `HALTED`.
- `MEM_WAIT` exits to `RUN`, or to `DRAIN` if it was entered from `DRAIN`, on the first cycle with `MemBusy`=0. A 1-bit `was_drain` flag records which.
- `HALTED`: `stall_F`=`stall_D`=`stall_E`=1, `nop_M`=1, `WEN_W`=1, `halted`=1. All other inputs are ignored. The only exit is `RST`.
- Forwarding, per source operand (same rule for B):
  - `FwdA_sel`=01 if !`RegWrEn_E` & !`IsLoad_E` & `Rdst_E`≠0 & `Rdst_E`==`RegAName_D`.
  - Else 10 if !`RegWrEn_M` & `Rdst_M`≠0 & `Rdst_M`==`RegAName_D`.
  - Else 00. EX has priority over MEM. x0 is never forwarded.
- `stall_cycles` increments on each negedge where `stall_F`=1 and state≠`HALTED`. It saturates at all-ones.
- `flush_count` increments once per accepted redirect. It saturates at all-ones.

## Timing
- Reset (`RST` low, async): state=`RUN`, `was_drain`=0, counters=0.
- Output values while `RST` is low: `halted`=0, all stall/nop=0, `WEN_M`=`WEN_W`=0, Fwd=00.
- State, `was_drain` and counters update on negedge `CLK`. Outputs settle before the same negedge that the pipeline registers sample.
- Load-use costs 1 cycle. The dependent instruction then sees `FwdX_sel`=10.
- Redirect costs 2 cycles, applied in the same cycle that `Redirect_E` is seen.
- `MemBusy` for N cycles stalls for exactly N cycles. A pending redirect fires in cycle N+1.
- `halted` rises at the negedge after `halt_W` is sampled high.
- `RST` asserted mid-`DRAIN` or mid-`MEM_WAIT` returns to `RUN` immediately. No partial counts are kept.

## Structure
- Package `pipe_ctrl_pkg`: state enum; `FWD_RF`=2'b00, `FWD_EX`=2'b01, `FWD_MEM`=2'b10; `NOP_INST`=32'h13.
- Sub-module `fwd_select` (combinational comparator plus priority), instantiated twice, once for A and once for B.
- The FSM, counters and priority encoder are in the top module.

## Test plan
- Load x5 in E (`IsLoad_E`=1, `RegWrEn_E`=0, `Rdst_E`=5), D has `RegAName_D`=5 and `UsesA_D`=1 → `stall_F`=`stall_D`=`nop_E`=1 for 1 cycle. Next cycle, with `Rdst_M`=5, `FwdA_sel`=10 and `stall_cycles`=1.
- Load to x0 with `RegAName_D`=0 → no stall and `FwdA_sel`=00. ALU op writing x7 in E with `RegBName_D`=7 → `FwdB_sel`=01.
- `Redirect_E`=1 while a load-use condition also holds → `nop_D`=`nop_E`=1, `stall_F`=0, `flush_count`=1.
- `MemBusy`=1 for 3 cycles with `Redirect_E`=1 → 3 cycles of full stall with `WEN_M`=`WEN_W`=1. `nop_D`/`nop_E` fire only in cycle 4. `stall_cycles`=3.
- `halt_D`, then `halt_W` 3 cycles later → 3 `DRAIN` cycles with `nop_D`=1, then `halted`=1 and frozen. Pulsing `RST` low → `halted`=0 and all outputs at reset values.
- Preload `stall_cycles`=16'hFFFF by running a long stall, then stall again → it stays at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encodings are also decoded by the Decode-stage operand muxes.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;

  localparam logic [1:0]  FWD_RF   = 2'b00;
  localparam logic [1:0]  FWD_EX   = 2'b01;
  localparam logic [1:0]  FWD_MEM  = 2'b10;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select and load-use detection for one Decode source.
// Write enables are active-low; x0 never forwards or stalls.
module fwd_select
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] reg_name,
  input  logic       uses,
  input  logic [4:0] rdst_e,
  input  logic       regwren_e,
  input  logic       is_load_e,
  input  logic [4:0] rdst_m,
  input  logic       regwren_m,
  output logic [1:0] sel,
  output logic       load_hit
);

  logic e_match;
  logic m_match;

  assign e_match = !regwren_e && (rdst_e != 5'd0) && (rdst_e == reg_name);
  assign m_match = !regwren_m && (rdst_m != 5'd0) && (rdst_m == reg_name);

  // A load in EX has no result yet, so it cannot feed the EX path.
  always_comb begin
    sel = FWD_RF;
    if (e_match && !is_load_e) begin
      sel = FWD_EX;
    end else if (m_match) begin
      sel = FWD_MEM;
    end
  end

  assign load_hit = uses && is_load_e && e_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall, bubble and write-enable controls for the
// pipeline registers, Decode forwarding selects, halt drain and perf counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int FLUSH_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [4:0]         RegAName_D,
  input  logic [4:0]         RegBName_D,
  input  logic               UsesA_D,
  input  logic               UsesB_D,
  input  logic [4:0]         Rdst_E,
  input  logic [4:0]         Rdst_M,
  input  logic               RegWrEn_E,
  input  logic               RegWrEn_M,
  input  logic               IsLoad_E,
  input  logic               Redirect_E,
  input  logic               MemBusy,
  input  logic               halt_D,
  input  logic               halt_W,
  output logic               stall_D,
  output logic               nop_D,
  output logic               stall_F,
  output logic               stall_E,
  output logic               nop_E,
  output logic               nop_M,
  output logic               WEN_M,
  output logic               WEN_W,
  output logic [1:0]         FwdA_sel,
  output logic [1:0]         FwdB_sel,
  output logic               halted,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [FLUSH_W-1:0] flush_count
);

  pipe_state_t        state_reg, state_next, eff_state;
  logic               was_drain_reg, was_drain_next;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [FLUSH_W-1:0] flush_cnt_reg;

  logic [4:0] src_name [2];
  logic       src_uses [2];
  logic [1:0] src_sel  [2];
  logic [1:0] load_hit;
  logic       load_use;

  logic stall_f_c, stall_d_c, nop_d_c, stall_e_c, nop_e_c, nop_m_c;
  logic wen_m_c, wen_w_c, accept_redirect;

  assign src_name[0] = RegAName_D;
  assign src_name[1] = RegBName_D;
  assign src_uses[0] = UsesA_D;
  assign src_uses[1] = UsesB_D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_select u_fwd (
        .reg_name  (src_name[gi]),
        .uses      (src_uses[gi]),
        .rdst_e    (Rdst_E),
        .regwren_e (RegWrEn_E),
        .is_load_e (IsLoad_E),
        .rdst_m    (Rdst_M),
        .regwren_m (RegWrEn_M),
        .sel       (src_sel[gi]),
        .load_hit  (load_hit[gi])
      );
    end
  endgenerate

  assign load_use = |load_hit;

  // Once memory frees up, MEM_WAIT behaves as the state it interrupted.
  always_comb begin
    eff_state = state_reg;
    if (state_reg == MEM_WAIT) begin
      eff_state = was_drain_reg ? DRAIN : RUN;
    end
  end

  always_comb begin
    stall_f_c       = 1'b0;
    stall_d_c       = 1'b0;
    nop_d_c         = 1'b0;
    stall_e_c       = 1'b0;
    nop_e_c         = 1'b0;
    nop_m_c         = 1'b0;
    wen_m_c         = 1'b0;
    wen_w_c         = 1'b0;
    accept_redirect = 1'b0;
    state_next      = state_reg;
    was_drain_next  = was_drain_reg;

    if (state_reg == HALTED) begin
      stall_f_c = 1'b1;
      stall_d_c = 1'b1;
      stall_e_c = 1'b1;
      nop_m_c   = 1'b1;
      wen_w_c   = 1'b1;
    end else if (MemBusy) begin
      // EX is frozen, so any redirect stays pending until memory is ready.
      stall_f_c      = 1'b1;
      stall_d_c      = 1'b1;
      stall_e_c      = 1'b1;
      wen_m_c        = 1'b1;
      wen_w_c        = 1'b1;
      state_next     = MEM_WAIT;
      was_drain_next = (eff_state == DRAIN);
    end else if (Redirect_E) begin
      nop_d_c         = 1'b1;
      nop_e_c         = 1'b1;
      accept_redirect = 1'b1;
      state_next      = RUN;
      was_drain_next  = 1'b0;
    end else begin
      state_next     = eff_state;
      was_drain_next = 1'b0;
      if (load_use) begin
        stall_f_c = 1'b1;
        stall_d_c = 1'b1;
        nop_e_c   = 1'b1;
      end else if (eff_state == DRAIN) begin
        stall_f_c = 1'b1;
        nop_d_c   = 1'b1;
      end
      if (eff_state == RUN && halt_D && !load_use) begin
        state_next = DRAIN;
      end
      if (eff_state == DRAIN && halt_W) begin
        state_next = HALTED;
      end
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= RUN;
      was_drain_reg <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      was_drain_reg <= was_drain_next;
      if (stall_f_c && state_reg != HALTED && stall_cnt_reg != '1) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (accept_redirect && flush_cnt_reg != '1) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  // Controls are forced quiet for as long as reset is held.
  assign stall_F      = RST & stall_f_c;
  assign stall_D      = RST & stall_d_c;
  assign nop_D        = RST & nop_d_c;
  assign stall_E      = RST & stall_e_c;
  assign nop_E        = RST & nop_e_c;
  assign nop_M        = RST & nop_m_c;
  assign WEN_M        = RST & wen_m_c;
  assign WEN_W        = RST & wen_w_c;
  assign halted       = RST & (state_reg == HALTED);
  assign FwdA_sel     = RST ? src_sel[0] : FWD_RF;
  assign FwdB_sel     = RST ? src_sel[1] : FWD_RF;
  assign stall_cycles = stall_cnt_reg;
  assign flush_count  = flush_cnt_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl; state advances on negedge CLK,
// inputs are driven and outputs sampled 1 ns after each negedge.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b1;
  logic        RST;
  logic [4:0]  RegAName_D, RegBName_D, Rdst_E, Rdst_M;
  logic        UsesA_D, UsesB_D, RegWrEn_E, RegWrEn_M, IsLoad_E;
  logic        Redirect_E, MemBusy, halt_D, halt_W;
  logic        stall_D, nop_D, stall_F, stall_E, nop_E, nop_M, WEN_M, WEN_W, halted;
  logic [1:0]  FwdA_sel, FwdB_sel;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;
  logic [8:0]  ctl;

  int total = 0;
  int bad   = 0;

  // {stall_F, stall_D, nop_D, stall_E, nop_E, nop_M, WEN_M, WEN_W, halted}
  localparam logic [8:0] C_IDLE  = 9'b000000000;
  localparam logic [8:0] C_LDUSE = 9'b110010000;
  localparam logic [8:0] C_FLUSH = 9'b001010000;
  localparam logic [8:0] C_BUSY  = 9'b110100110;
  localparam logic [8:0] C_DRAIN = 9'b101000000;
  localparam logic [8:0] C_HALT  = 9'b110101011;

  always #5 CLK = ~CLK;

  assign ctl = {stall_F, stall_D, nop_D, stall_E, nop_E, nop_M, WEN_M, WEN_W, halted};

  pipeline_hazard_ctrl #(.CNT_W(16), .FLUSH_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .RegAName_D(RegAName_D), .RegBName_D(RegBName_D),
    .UsesA_D(UsesA_D), .UsesB_D(UsesB_D),
    .Rdst_E(Rdst_E), .Rdst_M(Rdst_M),
    .RegWrEn_E(RegWrEn_E), .RegWrEn_M(RegWrEn_M),
    .IsLoad_E(IsLoad_E), .Redirect_E(Redirect_E), .MemBusy(MemBusy),
    .halt_D(halt_D), .halt_W(halt_W),
    .stall_D(stall_D), .nop_D(nop_D), .stall_F(stall_F),
    .stall_E(stall_E), .nop_E(nop_E), .nop_M(nop_M),
    .WEN_M(WEN_M), .WEN_W(WEN_W),
    .FwdA_sel(FwdA_sel), .FwdB_sel(FwdB_sel),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RegAName_D = 5'd0; RegBName_D = 5'd0; UsesA_D = 1'b0; UsesB_D = 1'b0;
    Rdst_E = 5'd0; Rdst_M = 5'd0; RegWrEn_E = 1'b1; RegWrEn_M = 1'b1;
    IsLoad_E = 1'b0; Redirect_E = 1'b0; MemBusy = 1'b0;
    halt_D = 1'b0; halt_W = 1'b0;
  endtask

  task automatic set_load_use();
    IsLoad_E = 1'b1; RegWrEn_E = 1'b0; Rdst_E = 5'd5;
    RegAName_D = 5'd5; UsesA_D = 1'b1;
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    #2;
    RST = 1'b1;
    #1;
  endtask

  initial begin
    clear_inputs();
    RST = 1'b0;
    set_load_use();
    Redirect_E = 1'b1;
    tick();
    check_val("reset_ctl", 32'(ctl), 32'(C_IDLE));
    check_val("reset_fwdA", 32'(FwdA_sel), 32'd0);
    check_val("reset_stall_cnt", 32'(stall_cycles), 32'd0);
    check_val("reset_flush_cnt", 32'(flush_count), 32'd0);
    RST = 1'b1;
    clear_inputs();
    tick();

    // Load-use bubble, then MEM forwarding for the dependent instruction
    set_load_use();
    #1;
    check_val("lduse_ctl", 32'(ctl), 32'(C_LDUSE));
    check_val("lduse_fwdA", 32'(FwdA_sel), 32'd0);
    tick();
    clear_inputs();
    RegAName_D = 5'd5; UsesA_D = 1'b1; Rdst_M = 5'd5; RegWrEn_M = 1'b0;
    #1;
    check_val("lduse_after_ctl", 32'(ctl), 32'(C_IDLE));
    check_val("lduse_after_fwdA", 32'(FwdA_sel), 32'd2);
    check_val("lduse_stall_cnt", 32'(stall_cycles), 32'd1);
    tick();

    // Load to x0 never stalls or forwards
    clear_inputs();
    IsLoad_E = 1'b1; RegWrEn_E = 1'b0; Rdst_E = 5'd0; RegAName_D = 5'd0; UsesA_D = 1'b1;
    Rdst_M = 5'd0; RegWrEn_M = 1'b0;
    #1;
    check_val("x0_ctl", 32'(ctl), 32'(C_IDLE));
    check_val("x0_fwdA", 32'(FwdA_sel), 32'd0);
    tick();

    // ALU result in EX wins over MEM for rs2
    clear_inputs();
    RegWrEn_E = 1'b0; Rdst_E = 5'd7; RegBName_D = 5'd7; UsesB_D = 1'b1;
    Rdst_M = 5'd7; RegWrEn_M = 1'b0;
    #1;
    check_val("alu_fwdB", 32'(FwdB_sel), 32'd1);
    check_val("alu_ctl", 32'(ctl), 32'(C_IDLE));
    tick();

    // Redirect beats load-use
    clear_inputs();
    pulse_reset();
    set_load_use();
    Redirect_E = 1'b1;
    #1;
    check_val("redir_ctl", 32'(ctl), 32'(C_FLUSH));
    tick();
    check_val("redir_flush_cnt", 32'(flush_count), 32'd1);
    check_val("redir_stall_cnt", 32'(stall_cycles), 32'd0);

    // MemBusy 3 cycles holds a pending redirect until cycle 4
    clear_inputs();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      MemBusy = 1'b1; Redirect_E = 1'b1;
      #1;
      check_val($sformatf("busy%0d_ctl", i), 32'(ctl), 32'(C_BUSY));
      tick();
    end
    MemBusy = 1'b0;
    #1;
    check_val("busy_release_ctl", 32'(ctl), 32'(C_FLUSH));
    check_val("busy_stall_cnt", 32'(stall_cycles), 32'd3);
    check_val("busy_flush_pre", 32'(flush_count), 32'd0);
    tick();
    check_val("busy_flush_post", 32'(flush_count), 32'd1);

    // Halt drain: three DRAIN cycles, halt_W on the third
    clear_inputs();
    halt_D = 1'b1;
    #1;
    check_val("halt_d_ctl", 32'(ctl), 32'(C_IDLE));
    tick();
    halt_D = 1'b0;
    for (int i = 0; i < 3; i++) begin
      halt_W = (i == 2);
      #1;
      check_val($sformatf("drain%0d_ctl", i), 32'(ctl), 32'(C_DRAIN));
      tick();
    end
    clear_inputs();
    #1;
    check_val("halted_ctl", 32'(ctl), 32'(C_HALT));
    MemBusy = 1'b1; Redirect_E = 1'b1;
    tick();
    tick();
    check_val("halted_frozen_ctl", 32'(ctl), 32'(C_HALT));
    check_val("halted_stall_cnt", 32'(stall_cycles), 32'd6);
    set_load_use();
    RST = 1'b0;
    #1;
    check_val("halt_rst_ctl", 32'(ctl), 32'(C_IDLE));
    check_val("halt_rst_cnt", 32'(stall_cycles), 32'd0);
    check_val("halt_rst_fwd", 32'(FwdA_sel), 32'd0);
    RST = 1'b1;
    clear_inputs();
    tick();

    // MemBusy during DRAIN returns to DRAIN; a redirect then cancels the drain
    halt_D = 1'b1;
    tick();
    halt_D = 1'b0;
    MemBusy = 1'b1;
    #1;
    check_val("drainbusy_ctl", 32'(ctl), 32'(C_BUSY));
    tick();
    MemBusy = 1'b0;
    #1;
    check_val("drainresume_ctl", 32'(ctl), 32'(C_DRAIN));
    tick();
    Redirect_E = 1'b1;
    #1;
    check_val("drainredir_ctl", 32'(ctl), 32'(C_FLUSH));
    tick();
    clear_inputs();
    #1;
    check_val("drainredir_run_ctl", 32'(ctl), 32'(C_IDLE));

    // Counter saturation, then reset mid-MEM_WAIT
    pulse_reset();
    MemBusy = 1'b1;
    repeat (65540) @(negedge CLK);
    #1;
    check_val("sat_stall_cnt", 32'(stall_cycles), 32'hFFFF);
    tick();
    tick();
    check_val("sat_hold_cnt", 32'(stall_cycles), 32'hFFFF);
    RST = 1'b0;
    #1;
    check_val("memwait_rst_ctl", 32'(ctl), 32'(C_IDLE));
    check_val("memwait_rst_cnt", 32'(stall_cycles), 32'd0);
    RST = 1'b1;
    MemBusy = 1'b0;
    #1;
    check_val("memwait_rst_run_ctl", 32'(ctl), 32'(C_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
